dvs_aer_transmitter: RTL and testbench



---
 rtl/dvs_aer_transmitter.sv | 184 ++++++++++++++++++
 tb/tb_dvs_aer_transmitter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvs_aer_transmitter.sv
// dvs_aer_transmitter
//   Sender side of a DVS-style AER link. Each accepted event (x, y, polarity)
//   goes out as two 4-phase req/ack words: a Y-address word (xsel=0) and then
//   an X-address + polarity word (xsel=1). aer/xsel are set up SETUP_CYCLES
//   clocks before req rises and stay put until the next SETUP state is entered.
//
//   Optional feature (macro DVS_AER_TX_ROW_REUSE_EN): remember the last row
//   whose Y word completed, and skip the Y word for events on the same row.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  event handshake (ready only in IDLE)
//   in_x/in_y       event address, in_polarity event polarity
//   aer, xsel, req  AER bus outputs (all registered)
//   ack             AER acknowledge, asynchronous (2-FF synchronised here)
//   busy            a word handshake is in progress
//   sent_count      completed events, wraps
module dvs_aer_transmitter #(
    parameter int X_ADDR_BITS  = 9,
    parameter int Y_ADDR_BITS  = 9,
    parameter int SETUP_CYCLES = 5,
    parameter int COUNT_BITS   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_ADDR_BITS-1:0] in_x,
    input  logic [Y_ADDR_BITS-1:0] in_y,
    input  logic                   in_polarity,
    output logic [9:0]             aer,
    output logic                   xsel,
    output logic                   req,
    input  logic                   ack,
    output logic                   busy,
    output logic [COUNT_BITS-1:0]  sent_count
);

    localparam int CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP_Y, REQ_Y, REL_Y, SETUP_X, REQ_X, REL_X
    } state_t;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic                    ack_meta, ack_sync;
    logic [X_ADDR_BITS-1:0]  x_q;
    logic [Y_ADDR_BITS-1:0]  y_q;
    logic                    pol_q;
    logic [9:0]              aer_d;
    logic                    xsel_d, req_d;
    logic [COUNT_BITS-1:0]   count_d;
    logic                    accept;
    logic                    skip_y;
    logic                    set_row;

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

`ifdef DVS_AER_TX_ROW_REUSE_EN
    logic [Y_ADDR_BITS-1:0] last_y;
    logic                   row_valid;

    assign skip_y = row_valid && (in_y == last_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_y    <= '0;
            row_valid <= 1'b0;
        end else if (set_row) begin
            last_y    <= y_q;
            row_valid <= 1'b1;
        end
    end
`else
    assign skip_y = 1'b0;
`endif

    // Next-state and next-output logic. Outputs are computed here and
    // registered below, so aer/xsel only move on the edge entering a SETUP state.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        aer_d   = aer;
        xsel_d  = xsel;
        req_d   = req;
        count_d = sent_count;
        set_row = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (skip_y) begin
                        state_d = SETUP_X;
                        aer_d   = 10'({in_x, in_polarity});
                        xsel_d  = 1'b1;
                    end else begin
                        state_d = SETUP_Y;
                        aer_d   = 10'(in_y);
                        xsel_d  = 1'b0;
                    end
                end
            end
            SETUP_Y: begin
                if (cnt == CNT_LAST) begin
                    state_d = REQ_Y;
                    req_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            REQ_Y: begin
                if (ack_sync) begin
                    state_d = REL_Y;
                    req_d   = 1'b0;
                end
            end
            REL_Y: begin
                if (!ack_sync) begin
                    state_d = SETUP_X;
                    cnt_d   = '0;
                    aer_d   = 10'({x_q, pol_q});
                    xsel_d  = 1'b1;
                    set_row = 1'b1;
                end
            end
            SETUP_X: begin
                if (cnt == CNT_LAST) begin
                    state_d = REQ_X;
                    req_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            REQ_X: begin
                if (ack_sync) begin
                    state_d = REL_X;
                    req_d   = 1'b0;
                end
            end
            REL_X: begin
                if (!ack_sync) begin
                    state_d = IDLE;
                    count_d = sent_count + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ack_meta   <= 1'b0;
            ack_sync   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            pol_q      <= 1'b0;
            aer        <= '0;
            xsel       <= 1'b0;
            req        <= 1'b0;
            sent_count <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            ack_meta   <= ack;
            ack_sync   <= ack_meta;
            aer        <= aer_d;
            xsel       <= xsel_d;
            req        <= req_d;
            sent_count <= count_d;
            if (accept) begin
                x_q   <= in_x;
                y_q   <= in_y;
                pol_q <= in_polarity;
            end
        end
    end

endmodule

// File: tb/tb_dvs_aer_transmitter.sv
module tb_dvs_aer_transmitter;
    localparam int XB = 9;
    localparam int YB = 9;
    localparam int SC = 5;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XB-1:0] in_x = '0;
    logic [YB-1:0] in_y = '0;
    logic          in_polarity = 1'b0;
    logic [9:0]    aer;
    logic          xsel, req, busy;
    logic          ack = 1'b0;
    logic [CB-1:0] sent_count;

    dvs_aer_transmitter #(.X_ADDR_BITS(XB), .Y_ADDR_BITS(YB), .SETUP_CYCLES(SC),
                          .COUNT_BITS(CB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_polarity(in_polarity), .aer(aer),
        .xsel(xsel), .req(req), .ack(ack), .busy(busy), .sent_count(sent_count));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ack_delay = 3;
    int ack_hold = 0;

    // words seen on the bus at each req rise, and how long each was set up
    logic [10:0] got_q[$];
    int          stab_q[$];
    // reference: words each accepted event must produce, and event count
    logic [10:0] exp_q[$];
    int          model_cnt = 0;
`ifdef DVS_AER_TX_ROW_REUSE_EN
    logic [YB-1:0] m_last_y = '0;
    bit            m_row_valid = 1'b0;
`endif

    int          stab = 0;
    logic [10:0] prev_w = '0;
    logic [10:0] mon_w;
    logic        prev_req = 1'b0;
    int          ready_viol = 0;
    int          hold_viol = 0;

    always @(negedge clk) begin
        mon_w = {xsel, aer};
        if (busy && in_ready) ready_viol++;
        if (req && prev_req && mon_w != prev_w) hold_viol++;
        if (req && !prev_req) begin
            got_q.push_back(mon_w);
            stab_q.push_back(stab);
        end
        if (!busy || req) stab = 0;
        else if (mon_w != prev_w || stab == 0) stab = 1;
        else stab++;
        prev_w   = mon_w;
        prev_req = req;
    end

    // 4-phase responder: raise ack ack_delay cycles after req, drop it
    // ack_delay+ack_hold cycles after req falls
    initial begin
        forever begin
            @(negedge clk);
            if (req && !ack) begin
                repeat (ack_delay) @(negedge clk);
                if (req) ack = 1'b1;
            end else if (!req && ack) begin
                repeat (ack_delay + ack_hold) @(negedge clk);
                ack = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic void model_accept(input logic [XB-1:0] x, input logic [YB-1:0] y,
                                         input logic p);
        bit skip;
        skip = 1'b0;
`ifdef DVS_AER_TX_ROW_REUSE_EN
        skip = m_row_valid && (y == m_last_y);
        m_last_y = y;
        m_row_valid = 1'b1;
`endif
        if (!skip) exp_q.push_back({1'b0, 10'(y)});
        exp_q.push_back({1'b1, 10'({x, p})});
    endfunction

    function automatic void model_reset();
        model_cnt = 0;
        exp_q.delete();
`ifdef DVS_AER_TX_ROW_REUSE_EN
        m_row_valid = 1'b0;
`endif
    endfunction

    // offer an event, return edges from acceptance to req rise
    task automatic offer(input logic [XB-1:0] x, input logic [YB-1:0] y, input logic p,
                         output int lat);
        int n;
        in_x = x; in_y = y; in_polarity = p; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin tick(); n++; end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            lat = -1;
            return;
        end
        model_accept(x, y, p);
        tick();
        // scramble inputs after acceptance; the latched event must be used
        in_valid = 1'b0; in_x = ~x; in_y = ~y; in_polarity = ~p;
        lat = 1;
        while (!req && lat < 100) begin tick(); lat++; end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin tick(); n++; end
        chk("idle_timeout", busy, 0);
        n = 0;
        while (ack && n < 200) begin tick(); n++; end
        repeat (3) tick();
    endtask

    task automatic check_words(input string tag);
        logic [10:0] e, g;
        int s;
        chk({tag, "_nwords"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            s = stab_q.pop_front();
            chk({tag, "_word"}, g, e);
            chk({tag, "_setup"}, s, SC);
        end
        got_q.delete(); stab_q.delete(); exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        wait_idle();
        got_q.delete(); stab_q.delete();
    endtask

    initial begin
        int lat, n, idle, hold, relcyc, k, ny, nx;
        logic [10:0] w0;
        logic [XB-1:0] rx;
        logic [YB-1:0] ry;

        // reset state
        repeat (3) tick();
        chk("rst_req", req, 0);
        chk("rst_aer", aer, 0);
        chk("rst_xsel", xsel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", sent_count, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);

        // reset in the middle of the X handshake
        offer(9'd100, 9'd200, 1'b0, lat);
        n = 0;
        while (!(req && xsel) && n < 300) begin tick(); n++; end
        chk("reach_req_x", req && xsel, 1);
        rst = 1'b1;
        tick();
        chk("midrst_req", req, 0);
        chk("midrst_aer", aer, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", sent_count, 0);
        rst = 1'b0;
        tick();
        chk("midrst_ready", in_ready, 1);
        model_reset();
        wait_idle();
        got_q.delete(); stab_q.delete();

        // base event
        ack_delay = 3;
        offer(9'd37, 9'd12, 1'b1, lat);
        chk("base_latency", lat, SC + 1);
        wait_idle();
        model_cnt++;
        chk("base_yword", got_q[0], {1'b0, 10'h00C});
        chk("base_xword", got_q[1], {1'b1, 10'h04B});
        check_words("base");
        chk("base_count", sent_count, model_cnt % (1 << CB));
        chk("base_ready", in_ready, 1);

        // back-to-back: second event held valid while busy
        offer(9'd20, 9'd40, 1'b0, lat);
        in_x = 9'd5; in_y = 9'd3; in_polarity = 1'b0; in_valid = 1'b1;
        idle = 0; n = 0;
        while (n < 3000) begin
            tick(); n++;
            if (!busy) idle++;
            else if (idle > 0) break;
        end
        model_accept(9'd5, 9'd3, 1'b0);
        in_valid = 1'b0;
        chk("b2b_idle_gap", idle, 1);
        wait_idle();
        model_cnt += 2;
        chk("b2b_yword", got_q[2], {1'b0, 10'h003});
        chk("b2b_xword", got_q[3], {1'b1, 10'h00A});
        check_words("b2b");
        chk("b2b_count", sent_count, model_cnt % (1 << CB));
        chk("ready_while_busy", ready_viol, 0);

        // slow ack release on the Y word
        ack_delay = 2; ack_hold = 40;
        offer(9'd9, 9'd9, 1'b1, lat);
        n = 0;
        while (req && n < 200) begin tick(); n++; end
        w0 = {xsel, aer};
        ack_hold = 0;
        hold = 0; relcyc = 0;
        while (ack && relcyc < 300) begin
            tick(); relcyc++;
            if (ack && (req || {xsel, aer} != w0)) hold++;
        end
        k = 0;
        while (!xsel && k < 20) begin
            tick(); k++;
            if (!xsel && (req || {xsel, aer} != w0)) hold++;
        end
        chk("slow_hold", hold, 0);
        chk("slow_long", relcyc >= 40, 1);
        chk("slow_sync", k, 3);
        wait_idle();
        model_cnt++;
        check_words("slow");
        chk("slow_count", sent_count, model_cnt % (1 << CB));

        // random events
        for (int i = 0; i < 12; i++) begin
            ack_delay = $urandom_range(1, 4);
            rx = XB'($urandom_range(0, 511));
            ry = YB'($urandom_range(0, 510));
            offer(rx, ry, 1'($urandom_range(0, 1)), lat);
            chk("rand_latency", lat, SC + 1);
            wait_idle();
            model_cnt++;
            check_words("rand");
            chk("rand_count", sent_count, model_cnt % (1 << CB));
        end

        // bring the counter to its top value, then wrap on a max-value event
        n = 0;
        while ((model_cnt % (1 << CB)) != (1 << CB) - 1 && n < 20) begin
            ack_delay = $urandom_range(1, 4);
            offer(XB'($urandom_range(0, 511)), YB'($urandom_range(0, 510)), 1'b0, lat);
            wait_idle();
            model_cnt++; n++;
            check_words("fill");
        end
        chk("fill_count", sent_count, (1 << CB) - 1);
        offer(9'd511, 9'd511, 1'b1, lat);
        wait_idle();
        model_cnt++;
        chk("max_yword", got_q[0], {1'b0, 10'h1FF});
        chk("max_xword", got_q[1], {1'b1, 10'h3FF});
        check_words("max");
        chk("wrap_count", sent_count, 0);

        // row bursts
        do_reset();
        offer(9'd1, 9'd7, 1'b0, lat); wait_idle();
        offer(9'd2, 9'd7, 1'b0, lat); wait_idle();
        offer(9'd3, 9'd8, 1'b0, lat); wait_idle();
        ny = 0; nx = 0;
        foreach (got_q[i]) if (got_q[i][10]) nx++; else ny++;
`ifdef DVS_AER_TX_ROW_REUSE_EN
        chk("row_ywords", ny, 2);
`else
        chk("row_ywords", ny, 3);
`endif
        chk("row_xwords", nx, 3);
        check_words("row");
        chk("row_count", sent_count, 3);
        chk("hold_under_req", hold_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
